// File: rtl/rr_arb_pkg.sv
// Shared switch-arbiter definitions: state encoding and index-width helper.
package rr_arb_pkg;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    typedef enum logic {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY
    } arb_state_t;

    // Never returns less than 1 so that degenerate sizes still give a legal vector.
    function automatic int arb_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb_if
    import rr_arb_pkg::*;
#(
    parameter int ARB_WIDTH    = 16,
    parameter int ARB_WIDTH_L2 = arb_idx_w(ARB_WIDTH)
);
    logic [ARB_WIDTH-1:0]    arb_req;
    logic                    arb_done;
    logic                    arb_gnt_vld;
    logic [ARB_WIDTH-1:0]    arb_gnt_vec;
    logic [ARB_WIDTH_L2-1:0] arb_gnt_bin;
    logic                    arb_tmo;

    modport master (
        output arb_req, arb_done,
        input  arb_gnt_vld, arb_gnt_vec, arb_gnt_bin, arb_tmo
    );

    modport slave (
        input  arb_req, arb_done,
        output arb_gnt_vld, arb_gnt_vec, arb_gnt_bin, arb_tmo
    );
endinterface

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder with one-hot and binary outputs.
module prio_enc
    import rr_arb_pkg::*;
#(
    parameter int PE_WIDTH = 16,
    parameter int PE_BIN_W = arb_idx_w(PE_WIDTH)
) (
    input  logic [PE_WIDTH-1:0] pe_vec_in,
    output logic                pe_found,
    output logic [PE_WIDTH-1:0] pe_vec_out,
    output logic [PE_BIN_W-1:0] pe_bin_out
);

    // Scan downward so the last hit, i.e. the lowest index, wins.
    always_comb begin
        pe_found   = 1'b0;
        pe_vec_out = '0;
        pe_bin_out = '0;
        for (int i = PE_WIDTH - 1; i >= 0; i--) begin
            if (pe_vec_in[i]) begin
                pe_found      = 1'b1;
                pe_vec_out    = '0;
                pe_vec_out[i] = 1'b1;
                pe_bin_out    = PE_BIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Packet-granular round-robin arbiter with grant lock and hold watchdog.
//   state | meaning
//   IDLE  | no grant held, pick next candidate at/after ptr
//   BUSY  | grant locked until abort, done or watchdog
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int ARB_WIDTH    = 16,
    parameter int ARB_WIDTH_L2 = arb_idx_w(ARB_WIDTH),
    parameter int ARB_TMO      = 4096,
    parameter int ARB_TMO_W    = arb_idx_w(ARB_TMO + 1)
) (
    input logic      clk,
    input logic      rstn,
    rr_arb_if.slave  arb
);

    localparam logic [ARB_TMO_W-1:0] TMO_LAST = ARB_TMO_W'((ARB_TMO == 0) ? 0 : ARB_TMO - 1);
    localparam logic [ARB_TMO_W-1:0] TMO_SAT  = {ARB_TMO_W{1'b1}};
    localparam logic [ARB_WIDTH_L2-1:0] LAST_IDX = ARB_WIDTH_L2'(ARB_WIDTH - 1);

    arb_state_t              state_q, state_nxt;
    logic [ARB_WIDTH_L2-1:0] ptr_q, ptr_nxt;
    logic [ARB_TMO_W-1:0]    cnt_q, cnt_nxt;
    logic                    vld_q, vld_nxt;
    logic [ARB_WIDTH-1:0]    vec_q, vec_nxt;
    logic [ARB_WIDTH_L2-1:0] bin_q, bin_nxt;
    logic                    tmo_q, tmo_nxt;

    logic [ARB_WIDTH-1:0]    mask;
    logic [ARB_WIDTH-1:0]    req_masked;
    logic                    m_found, r_found;
    logic [ARB_WIDTH-1:0]    m_vec, r_vec;
    logic [ARB_WIDTH_L2-1:0] m_bin, r_bin;
    logic                    rel_abort, rel_done, rel_tmo;

    always_comb begin
        mask = '0;
        for (int i = 0; i < ARB_WIDTH; i++) begin
            mask[i] = (ARB_WIDTH_L2'(i) >= ptr_q);
        end
    end

    assign req_masked = arb.arb_req & mask;

    prio_enc #(.PE_WIDTH(ARB_WIDTH), .PE_BIN_W(ARB_WIDTH_L2)) u_pe_masked (
        .pe_vec_in  (req_masked),
        .pe_found   (m_found),
        .pe_vec_out (m_vec),
        .pe_bin_out (m_bin)
    );

    prio_enc #(.PE_WIDTH(ARB_WIDTH), .PE_BIN_W(ARB_WIDTH_L2)) u_pe_raw (
        .pe_vec_in  (arb.arb_req),
        .pe_found   (r_found),
        .pe_vec_out (r_vec),
        .pe_bin_out (r_bin)
    );

    assign rel_abort = ~arb.arb_req[bin_q];
    assign rel_done  = arb.arb_done;
    assign rel_tmo   = (ARB_TMO != 0) && (cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            vec_q   <= '0;
            bin_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
            vld_q   <= vld_nxt;
            vec_q   <= vec_nxt;
            bin_q   <= bin_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        vld_nxt   = vld_q;
        vec_nxt   = vec_q;
        bin_nxt   = bin_q;
        tmo_nxt   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (m_found || r_found) begin
                    state_nxt = ST_BUSY;
                    vld_nxt   = 1'b1;
                    vec_nxt   = m_found ? m_vec : r_vec;
                    bin_nxt   = m_found ? m_bin : r_bin;
                    cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                cnt_nxt = (cnt_q == TMO_SAT) ? cnt_q : cnt_q + ARB_TMO_W'(1);
                if (rel_abort || rel_done || rel_tmo) begin
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                    vec_nxt   = '0;
                    bin_nxt   = '0;
                    ptr_nxt   = (bin_q == LAST_IDX) ? '0 : bin_q + ARB_WIDTH_L2'(1);
                    // Timeout is only reported when it is the sole reason for release.
                    tmo_nxt   = rel_tmo && !rel_abort && !rel_done;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign arb.arb_gnt_vld = vld_q;
    assign arb.arb_gnt_vec = vec_q;
    assign arb.arb_gnt_bin = bin_q;
    assign arb.arb_tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb.sv
// Directed bench for rr_arb: rotation, wrap, abort, watchdog and async reset.
module tb_rr_arb;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   drops;

    rr_arb_if #(.ARB_WIDTH(16)) if_main ();
    rr_arb_if #(.ARB_WIDTH(16)) if_t8 ();
    rr_arb_if #(.ARB_WIDTH(16)) if_t0 ();

    rr_arb #(.ARB_WIDTH(16), .ARB_TMO(4096)) u_main (.clk(clk), .rstn(rstn), .arb(if_main));
    rr_arb #(.ARB_WIDTH(16), .ARB_TMO(8))    u_t8   (.clk(clk), .rstn(rstn), .arb(if_t8));
    rr_arb #(.ARB_WIDTH(16), .ARB_TMO(0))    u_t0   (.clk(clk), .rstn(rstn), .arb(if_t0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [15:0] exp_vec, input logic [3:0] exp_bin);
        chk({tag, "_vld"}, 32'(if_main.arb_gnt_vld), 32'd1);
        chk({tag, "_vec"}, 32'(if_main.arb_gnt_vec), 32'(exp_vec));
        chk({tag, "_bin"}, 32'(if_main.arb_gnt_bin), 32'(exp_bin));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drops  = 0;
        rstn   = 1'b0;
        if_main.arb_req = '0; if_main.arb_done = 1'b0;
        if_t8.arb_req   = '0; if_t8.arb_done   = 1'b0;
        if_t0.arb_req   = '0; if_t0.arb_done   = 1'b0;

        repeat (2) tick();
        chk("rst_vld", 32'(if_main.arb_gnt_vld), 32'd0);
        chk("rst_vec", 32'(if_main.arb_gnt_vec), 32'd0);
        chk("rst_bin", 32'(if_main.arb_gnt_bin), 32'd0);
        chk("rst_tmo", 32'(if_main.arb_tmo), 32'd0);
        rstn = 1'b1;

        // Rotation: all request, done one cycle after each grant.
        if_main.arb_req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            tick();
            chk_gnt($sformatf("rot%0d", k), 16'(1 << (k % 16)), 4'(k % 16));
            if_main.arb_done = 1'b1;
            tick();
            chk($sformatf("rot%0d_rel", k), 32'(if_main.arb_gnt_vld), 32'd0);
            if_main.arb_done = 1'b0;
            if (k == 16) if_main.arb_req = 16'h0010;
        end

        // Single requester 4, then ptr=5 wraps 0009 to 0, next pass skips to 3.
        tick();
        chk_gnt("single", 16'h0010, 4'd4);
        if_main.arb_done = 1'b1;
        tick();
        chk("single_rel", 32'(if_main.arb_gnt_vld), 32'd0);
        if_main.arb_done = 1'b0;
        if_main.arb_req  = 16'h0009;
        tick();
        chk_gnt("wrap", 16'h0001, 4'd0);
        if_main.arb_done = 1'b1;
        tick();
        chk("wrap_rel", 32'(if_main.arb_gnt_vld), 32'd0);
        if_main.arb_done = 1'b0;
        tick();
        chk_gnt("skip", 16'h0008, 4'd3);
        if_main.arb_done = 1'b1;
        if_main.arb_req  = 16'h0000;
        tick();
        chk("skip_rel", 32'(if_main.arb_gnt_vld), 32'd0);
        if_main.arb_done = 1'b0;

        // Abort: ptr=4, only 2 requests -> wrap grant 2; drop it -> ptr=3.
        if_main.arb_req = 16'h0004;
        tick();
        chk_gnt("abort_gnt", 16'h0004, 4'd2);
        if_main.arb_req = 16'h0000;
        tick();
        chk("abort_vld", 32'(if_main.arb_gnt_vld), 32'd0);
        chk("abort_tmo", 32'(if_main.arb_tmo), 32'd0);
        if_main.arb_req = 16'h000F;
        tick();
        chk_gnt("abort_ptr", 16'h0008, 4'd3);
        if_main.arb_req  = 16'h0000;
        if_main.arb_done = 1'b1;
        tick();
        chk("abort_ptr_rel", 32'(if_main.arb_gnt_vld), 32'd0);
        if_main.arb_done = 1'b0;

        // Watchdog ARB_TMO=8: release and pulse 8 edges after grant.
        if_t8.arb_req = 16'h0020;
        tick();
        chk("wd_gnt_vld", 32'(if_t8.arb_gnt_vld), 32'd1);
        chk("wd_gnt_bin", 32'(if_t8.arb_gnt_bin), 32'd5);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("wd_hold%0d_vld", i), 32'(if_t8.arb_gnt_vld), 32'd1);
            chk($sformatf("wd_hold%0d_tmo", i), 32'(if_t8.arb_tmo), 32'd0);
        end
        tick();
        chk("wd_exp_vld", 32'(if_t8.arb_gnt_vld), 32'd0);
        chk("wd_exp_tmo", 32'(if_t8.arb_tmo), 32'd1);
        tick();
        chk("wd_regnt_vld", 32'(if_t8.arb_gnt_vld), 32'd1);
        chk("wd_pulse_end", 32'(if_t8.arb_tmo), 32'd0);
        repeat (7) tick();
        chk("wd_pre_coinc_vld", 32'(if_t8.arb_gnt_vld), 32'd1);
        if_t8.arb_req = 16'h0000;
        tick();
        chk("wd_coinc_vld", 32'(if_t8.arb_gnt_vld), 32'd0);
        chk("wd_coinc_tmo", 32'(if_t8.arb_tmo), 32'd0);

        // ARB_TMO=0: grant held indefinitely.
        if_t0.arb_req = 16'h0001;
        tick();
        chk("nowd_gnt", 32'(if_t0.arb_gnt_vld), 32'd1);
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (if_t0.arb_gnt_vld !== 1'b1 || if_t0.arb_tmo !== 1'b0) drops++;
        end
        chk("nowd_drops", 32'(drops), 32'd0);
        chk("nowd_bin", 32'(if_t0.arb_gnt_bin), 32'd0);
        if_t0.arb_req = 16'h0000;
        tick();
        chk("nowd_rel", 32'(if_t0.arb_gnt_vld), 32'd0);

        // Async reset mid-grant (ptr would otherwise favour 15 next).
        if_main.arb_req = 16'h0040;
        tick();
        chk_gnt("ar_gnt", 16'h0040, 4'd6);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_vld", 32'(if_main.arb_gnt_vld), 32'd0);
        chk("ar_vec", 32'(if_main.arb_gnt_vec), 32'd0);
        chk("ar_bin", 32'(if_main.arb_gnt_bin), 32'd0);
        chk("ar_tmo", 32'(if_main.arb_tmo), 32'd0);
        #1;
        rstn = 1'b1;
        if_main.arb_req = 16'h8001;
        tick();
        chk_gnt("ar_post", 16'h0001, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb.md
# rr_arb

Packet-granular round-robin arbiter that shares one resource (e.g. an egress port's frame buffer write path) among ARB_WIDTH requesters in the switch. Each arbitration pass picks the next requester at or above a rotating pointer, using two `prio_enc` lowest-index-wins encoders: one on masked requests, one on raw requests. The grant is locked until the winner signals end-of-packet, drops its request, or a watchdog expires.

## Interface
- ARB_WIDTH, 16: number of requesters; must be 2 or more.
- ARB_WIDTH_L2, $clog2(ARB_WIDTH): index width.
- ARB_TMO, 4096: maximum cycles a grant may be held; 0 disables the watchdog.
- ARB_TMO_W, $clog2(ARB_TMO+1): watchdog counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- arb_req  in  ARB_WIDTH  level request per requester.
- arb_done  in  1  end-of-packet pulse from the current grantee; ignored unless in BUSY.
- arb_gnt_vld  out  1  a grant is held.
- arb_gnt_vec  out  ARB_WIDTH  one-hot grant; all zero when arb_gnt_vld=0.
- arb_gnt_bin  out  ARB_WIDTH_L2  binary index of the grantee; 0 when idle.
- arb_tmo  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- Reset state: IDLE, ptr=0, tmo_cnt=0, and all outputs 0.
- Mask: mask[i] = (i >= ptr).
- Candidate selection:
  - If masked requests (arb_req & mask) are non-zero, the candidate is their lowest set bit.
  - Otherwise, if arb_req is non-zero, the candidate is the lowest set bit of arb_req (wrap).
  - Otherwise there is no candidate.
- IDLE:
  - With a candidate: register the grant (vec, bin, vld=1), clear tmo_cnt, go to BUSY.
  - Without a candidate: stay in IDLE.
- BUSY: the grant is held; all other requests are ignored.
- Release conditions, checked in BUSY each cycle in priority order:
  1. arb_req[gnt_bin]==0: abort.
  2. arb_done==1: normal end of packet.
  3. ARB_TMO!=0 and tmo_cnt==ARB_TMO-1: timeout; arb_tmo pulses in the same registered update as the release.
- On any release:
  - Clear the grant and go to IDLE.
  - ptr <= gnt_bin+1, wrapping to 0 when gnt_bin==ARB_WIDTH-1.
  - If abort and timeout coincide, the release is treated as an abort and arb_tmo stays 0.
- tmo_cnt increments every BUSY cycle, saturates, and is cleared on grant.
- Fairness: a requester that holds arb_req high is granted within ARB_WIDTH-1 other grants.
- Reset asserted mid-grant: outputs clear immediately (asynchronous); ptr returns to 0.

## Timing
- Request to grant: arb_req sampled in IDLE at edge t gives arb_gnt_vld=1 after edge t.
- Release: arb_done=1 at edge t drops arb_gnt_vld after t, leaving one IDLE cycle. The next grant is visible after edge t+1.
- Back-to-back packets from a single requester therefore see one bubble cycle.
- Holding a grant with ARB_TMO=N: if vld rises after edge t, vld falls and arb_tmo pulses after edge t+N.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared switch utility package holds the state encoding localparams (ARB_IDLE=1'b0, ARB_BUSY=1'b1) and an index-width function/macro shared with other arbiters.
- Sub-module: two instances of the existing `prio_enc` (PE_WIDTH=ARB_WIDTH), one on masked and one on raw requests, each using pe_found, pe_vec_out and pe_bin_out.
- Top level contains the FSM, pointer, watchdog and output registers; about 150–200 lines.

## Test plan
- **Single requester:** reset, then arb_req=16'h0010.
  - Expect vld=1, vec=16'h0010, bin=4 one cycle later.
  - arb_done pulse → vld=0 the next cycle, and ptr=5.
- **Rotation:** arb_req=16'hFFFF held, arb_done pulsed one cycle after each grant. Expect the grant sequence 0,1,2,…,15,0.
- **Wrap and skip:** ptr=5 with arb_req=16'h0009 gives grant 0 (wrap); the next pass gives 3.
- **Abort:** after grant to requester 2, drop arb_req[2] → vld=0 the next cycle, with arb_tmo=0 and ptr=3.
- **Watchdog:** ARB_TMO=8, granted requester holds its request without arb_done.
  - Expect arb_tmo pulse and vld=0 exactly 8 cycles after vld rose.
  - ARB_TMO=0 → the grant is held indefinitely (check 10000 cycles).
- **Async reset:** assert rstn=0 mid-grant between clock edges → vld, vec, bin and arb_tmo are 0 immediately. After release, arb_req=16'h8001 grants 0.
